conv_pass_scheduler: RTL and testbench

//  Sequences a full 2-D separable Gaussian blur as two conv_row_controller passes.

---
 rtl/conv_pass_scheduler_pkg.sv | 49 ++++
 rtl/img_sram_intf.sv | 12 +
 rtl/conv_pass_scheduler_sram_port_mux.sv | 49 ++++
 rtl/conv_pass_scheduler.sv | 145 ++++++++++++++
 tb/tb_conv_pass_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pass_scheduler_pkg.sv
// Shared types for the two-pass separable blur scheduler: FSM states, SRAM
// request bundle and the smallest legal image dimension.
package conv_pkg;

    typedef logic [7:0] dim_t;
    typedef logic [7:0] pix_t;

    localparam dim_t MIN_DIM = 8'd6;

    typedef enum logic [2:0] {
        IDLE,
        P1_RST,
        P1_WAIT,
        P1_RUN,
        P2_RST,
        P2_WAIT,
        P2_RUN,
        DONE
    } sched_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_HOST,
        SRC_RC_IMG,
        SRC_RC_BUF
    } sram_src_e;

    typedef struct packed {
        logic write_en;
        logic sense_en;
        dim_t row;
        dim_t col;
        pix_t din;
    } sram_req_t;

    function automatic sram_req_t pick_req(sram_src_e src, sram_req_t host,
                                           sram_req_t rc_img, sram_req_t rc_buf);
        sram_req_t r;
        r = '0;
        unique case (src)
            SRC_HOST:   r = host;
            SRC_RC_IMG: r = rc_img;
            SRC_RC_BUF: r = rc_buf;
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/img_sram_intf.sv
// Single-port image SRAM access bundle: the requester drives req, the memory
// side returns registered read data on dout.
interface img_sram_intf;
    import conv_pkg::*;

    sram_req_t req;
    pix_t      dout;

    modport mst (output req, input dout);
    modport slv (input req, output dout);

endinterface

// File: rtl/conv_pass_scheduler_sram_port_mux.sv
// Stateless 3-slave to 2-master SRAM crossbar; the grant is decoded from the
// registered scheduler state so the select never glitches mid-cycle.
module sram_port_mux
    import conv_pkg::*;
(
    input  sched_state_e     sel,
    img_sram_intf.slv        host_sram,
    img_sram_intf.slv        rc_img,
    img_sram_intf.slv        rc_buf,
    img_sram_intf.mst        mem_img,
    img_sram_intf.mst        mem_buf
);

    sram_src_e img_src;
    sram_src_e buf_src;

    // Pass 2 swaps roles: the controller reads buf and writes back into img.
    always_comb begin
        img_src = SRC_NONE;
        buf_src = SRC_NONE;
        unique case (sel)
            IDLE, DONE: img_src = SRC_HOST;
            P1_WAIT, P1_RUN: begin
                img_src = SRC_RC_IMG;
                buf_src = SRC_RC_BUF;
            end
            P2_WAIT, P2_RUN: begin
                img_src = SRC_RC_BUF;
                buf_src = SRC_RC_IMG;
            end
            default: begin
                img_src = SRC_NONE;
                buf_src = SRC_NONE;
            end
        endcase
    end

    assign mem_img.req = pick_req(img_src, host_sram.req, rc_img.req, rc_buf.req);
    assign mem_buf.req = pick_req(buf_src, host_sram.req, rc_img.req, rc_buf.req);

    assign host_sram.dout = (img_src == SRC_HOST) ? mem_img.dout : '0;

    assign rc_img.dout = (img_src == SRC_RC_IMG) ? mem_img.dout :
                         (buf_src == SRC_RC_IMG) ? mem_buf.dout : '0;

    assign rc_buf.dout = (img_src == SRC_RC_BUF) ? mem_img.dout :
                         (buf_src == SRC_RC_BUF) ? mem_buf.dout : '0;

endmodule

// File: rtl/conv_pass_scheduler.sv
// Runs a 2-D separable blur as two transposing row-controller passes and owns
// the SRAM routing. Optional per-pass watchdog: define CONV_SCHED_TIMEOUT_EN.
module conv_pass_scheduler
    import conv_pkg::*;
`ifdef CONV_SCHED_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 131072
)
`endif
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [7:0]       nrows,
    input  logic [7:0]       ncols,
    input  logic [2:0]       sigma,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             rc_rstn,
    output logic [7:0]       rc_nrows,
    output logic [7:0]       rc_ncols,
    output logic [2:0]       rc_sigma,
    output logic             rc_transpose,
    input  logic             rc_busy,
    img_sram_intf.slv        host_sram,
    img_sram_intf.slv        rc_img,
    img_sram_intf.slv        rc_buf,
    img_sram_intf.mst        mem_img,
    img_sram_intf.mst        mem_buf
);

    sched_state_e state;
    logic         wd_expired;

    assign rc_transpose = 1'b1;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wd_cnt;
    logic          in_pass;

    assign in_pass = (state == P1_WAIT) || (state == P1_RUN) ||
                     (state == P2_WAIT) || (state == P2_RUN);

    // Cleared while in *_RST so the first *_WAIT cycle counts as zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
        end else if (in_pass) begin
            wd_cnt <= wd_cnt + TW'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expired = in_pass && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rc_rstn  <= 1'b0;
            rc_nrows <= '0;
            rc_ncols <= '0;
            rc_sigma <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (nrows >= MIN_DIM && ncols >= MIN_DIM) begin
                            state    <= P1_RST;
                            err      <= 1'b0;
                            rc_nrows <= nrows;
                            rc_ncols <= ncols;
                            rc_sigma <= sigma;
                        end else begin
                            state <= DONE;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                end
                P1_RST: begin
                    state   <= P1_WAIT;
                    rc_rstn <= 1'b1;
                end
                P1_WAIT: begin
                    if (rc_busy) state <= P1_RUN;
                end
                P1_RUN: begin
                    if (!rc_busy) begin
                        state    <= P2_RST;
                        rc_rstn  <= 1'b0;
                        rc_nrows <= rc_ncols;
                        rc_ncols <= rc_nrows;
                    end
                end
                P2_RST: begin
                    state   <= P2_WAIT;
                    rc_rstn <= 1'b1;
                end
                P2_WAIT: begin
                    if (rc_busy) state <= P2_RUN;
                end
                P2_RUN: begin
                    if (!rc_busy) begin
                        state   <= DONE;
                        rc_rstn <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (wd_expired) begin
                state   <= DONE;
                err     <= 1'b1;
                done    <= 1'b1;
                rc_rstn <= 1'b0;
            end
        end
    end

    sram_port_mux u_mux (
        .sel       (state),
        .host_sram (host_sram),
        .rc_img    (rc_img),
        .rc_buf    (rc_buf),
        .mem_img   (mem_img),
        .mem_buf   (mem_buf)
    );

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Bench for conv_pass_scheduler: stand-in row controller, two SRAM models and
// a whole-image reference blur computed directly on arrays.
module tb_conv_pass_scheduler;
    import conv_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] nrows = '0;
    logic [7:0] ncols = '0;
    logic [2:0] sigma = '0;
    logic       busy, done, err, rc_rstn, rc_transpose;
    logic [7:0] rc_nrows, rc_ncols;
    logic [2:0] rc_sigma;
    logic       rc_busy;
    logic       rc_hold = 1'b0;

    img_sram_intf host_if ();
    img_sram_intf rc_img_if ();
    img_sram_intf rc_buf_if ();
    img_sram_intf mem_img_if ();
    img_sram_intf mem_buf_if ();

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int unsigned TMO = 64;
    conv_pass_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn), .start(start), .nrows(nrows), .ncols(ncols), .sigma(sigma),
        .busy(busy), .done(done), .err(err), .rc_rstn(rc_rstn), .rc_nrows(rc_nrows),
        .rc_ncols(rc_ncols), .rc_sigma(rc_sigma), .rc_transpose(rc_transpose), .rc_busy(rc_busy),
        .host_sram(host_if), .rc_img(rc_img_if), .rc_buf(rc_buf_if),
        .mem_img(mem_img_if), .mem_buf(mem_buf_if));
`else
    conv_pass_scheduler dut (
        .clk(clk), .rstn(rstn), .start(start), .nrows(nrows), .ncols(ncols), .sigma(sigma),
        .busy(busy), .done(done), .err(err), .rc_rstn(rc_rstn), .rc_nrows(rc_nrows),
        .rc_ncols(rc_ncols), .rc_sigma(rc_sigma), .rc_transpose(rc_transpose), .rc_busy(rc_busy),
        .host_sram(host_if), .rc_img(rc_img_if), .rc_buf(rc_buf_if),
        .mem_img(mem_img_if), .mem_buf(mem_buf_if));
`endif

    // Physical SRAMs: synchronous write, registered read.
    pix_t img_mem [256][256];
    pix_t buf_mem [256][256];

    always @(posedge clk) begin
        if (mem_img_if.req.write_en) img_mem[mem_img_if.req.row][mem_img_if.req.col] <= mem_img_if.req.din;
        if (mem_img_if.req.sense_en) mem_img_if.dout <= img_mem[mem_img_if.req.row][mem_img_if.req.col];
        if (mem_buf_if.req.write_en) buf_mem[mem_buf_if.req.row][mem_buf_if.req.col] <= mem_buf_if.req.din;
        if (mem_buf_if.req.sense_en) mem_buf_if.dout <= buf_mem[mem_buf_if.req.row][mem_buf_if.req.col];
    end

    function automatic pix_t tap3(pix_t a, pix_t b, pix_t c);
        int unsigned s;
        s = int'(a) + 2 * int'(b) + int'(c) + 2;
        return pix_t'(s >> 2);
    endfunction

    // Stand-in row controller: 1-D [1 2 1]/4 filter per row, written transposed.
    task automatic rc_tick(output bit alive);
        @(posedge clk);
        #2;
        alive = rc_rstn;
    endtask

    task automatic model_pass();
        int   nr, nc, lc, hc;
        pix_t line [256];
        bit   alive;
        nr = int'(rc_nrows);
        nc = int'(rc_ncols);
        rc_tick(alive);
        if (!alive) return;
        rc_busy = 1'b1;
        if (rc_hold) begin
            while (alive) rc_tick(alive);
            rc_busy = 1'b0;
            return;
        end
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                rc_img_if.req = '{write_en: 1'b0, sense_en: 1'b1, row: dim_t'(r), col: dim_t'(c), din: 8'h00};
                rc_tick(alive);
                if (!alive) begin rc_img_if.req = '0; rc_busy = 1'b0; return; end
                line[c] = rc_img_if.dout;
            end
            rc_img_if.req = '0;
            for (int c = 0; c < nc; c++) begin
                lc = (c == 0) ? 0 : c - 1;
                hc = (c == nc - 1) ? c : c + 1;
                rc_buf_if.req = '{write_en: 1'b1, sense_en: 1'b0, row: dim_t'(c), col: dim_t'(r),
                                  din: tap3(line[lc], line[c], line[hc])};
                rc_tick(alive);
                if (!alive) begin rc_buf_if.req = '0; rc_busy = 1'b0; return; end
            end
            rc_buf_if.req = '0;
        end
        rc_busy = 1'b0;
    endtask

    initial begin : rc_model
        bit prev;
        prev = 1'b0;
        rc_busy = 1'b0;
        rc_img_if.req = '0;
        rc_buf_if.req = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rc_rstn && !prev) model_pass();
            prev = rc_rstn;
        end
    end

    // Source image and expected 2-D blur: horizontal pass then vertical pass.
    pix_t src    [16][16];
    pix_t exph   [16][16];
    pix_t expimg [16][16];
    pix_t got    [16][16];

    task automatic host_write(input int r, input int c, input pix_t d);
        host_if.req = '{write_en: 1'b1, sense_en: 1'b0, row: dim_t'(r), col: dim_t'(c), din: d};
        @(posedge clk); #1;
        host_if.req = '0;
    endtask

    task automatic host_read(input int r, input int c, output pix_t d);
        host_if.req = '{write_en: 1'b0, sense_en: 1'b1, row: dim_t'(r), col: dim_t'(c), din: 8'h00};
        @(posedge clk); #1;
        d = host_if.dout;
        host_if.req = '0;
    endtask

    task automatic load_image(input int nr, input int nc);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) begin
                src[r][c] = pix_t'($urandom);
                host_write(r, c, src[r][c]);
            end
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                exph[r][c] = tap3(src[r][(c > 0) ? c - 1 : 0], src[r][c], src[r][(c < nc - 1) ? c + 1 : c]);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                expimg[r][c] = tap3(exph[(r > 0) ? r - 1 : 0][c], exph[r][c], exph[(r < nr - 1) ? r + 1 : r][c]);
    endtask

    task automatic read_image(input int nr, input int nc);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                host_read(r, c, got[r][c]);
    endtask

    // Job statistics gathered while a start is being processed.
    int          j_done, j_low, j_busy, j_we, j_first_done, j_rises, j_rise_cyc, j_cfg_bad;
    logic [15:0] j_d1, j_d2;
    bit          j_finished;
    logic        j_err0, j_poke_we;
    pix_t        j_host_dout;

    task automatic run_job(input int nr, input int nc, input logic [2:0] sg, input bit poke);
        bit prev, poked, poke_now;
        nrows = 8'(nr); ncols = 8'(nc); sigma = sg;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        j_done = 0; j_low = 0; j_busy = 0; j_we = 0; j_first_done = -1; j_rises = 0;
        j_rise_cyc = -1; j_cfg_bad = 0; j_d1 = '0; j_d2 = '0; j_finished = 1'b0;
        j_err0 = err; j_poke_we = 1'b0; j_host_dout = 8'hAA;
        prev = 1'b0; poked = 1'b0; poke_now = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (done) begin j_done++; if (j_first_done < 0) j_first_done = cyc; end
            if (busy) j_busy++;
            if (busy && !rc_rstn) j_low++;
            if (mem_img_if.req.write_en || mem_buf_if.req.write_en) j_we++;
            if (rc_rstn && !prev) begin
                j_rises++;
                if (j_rise_cyc < 0) j_rise_cyc = cyc;
                if (j_rises == 1) j_d1 = {rc_nrows, rc_ncols}; else j_d2 = {rc_nrows, rc_ncols};
                if (rc_sigma !== sg || rc_transpose !== 1'b1) j_cfg_bad++;
            end
            prev = rc_rstn;
            if (j_done > 0 && !busy && !done) begin j_finished = 1'b1; break; end
            if (poke && !poked && j_rises == 1 && rc_busy && busy) begin
                poked = 1'b1; poke_now = 1'b1;
                start = 1'b1; nrows = 8'd7; ncols = 8'd9;
                host_if.req = '{write_en: 1'b1, sense_en: 1'b1, row: 8'd0, col: 8'd0, din: 8'hFF};
                #1;
                j_poke_we = mem_img_if.req.write_en;
            end
            @(posedge clk); #1;
            if (poke_now) begin
                poke_now = 1'b0; start = 1'b0;
                j_host_dout = host_if.dout;
                host_if.req = '0;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (rc_rstn !== 1'b0) begin errors++; $display("FAIL reset_rc_rstn got=%b exp=0", rc_rstn); end
        checks++; if ({rc_nrows, rc_ncols, rc_sigma} !== 19'd0) begin errors++;
            $display("FAIL reset_cfg got=%h/%h/%h exp=0/0/0", rc_nrows, rc_ncols, rc_sigma); end
        checks++; if (mem_buf_if.req !== '0) begin errors++; $display("FAIL reset_buf_idle got=%h exp=0", mem_buf_if.req); end
    endtask

    task automatic test_basic_8x8();
        load_image(8, 8);
        run_job(8, 8, 3'd2, 1'b0);
        checks++; if (!j_finished) begin errors++; $display("FAIL basic_finish got=0 exp=1"); end
        checks++; if (j_done !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", j_done); end
        checks++; if (j_low !== 3) begin errors++; $display("FAIL basic_rc_rstn_low got=%0d exp=3", j_low); end
        checks++; if (j_rises !== 2) begin errors++; $display("FAIL basic_pass_count got=%0d exp=2", j_rises); end
        checks++; if (j_d2 !== {8'd8, 8'd8}) begin errors++; $display("FAIL basic_p2_dims got=%h exp=0808", j_d2); end
        checks++; if (j_cfg_bad !== 0) begin errors++; $display("FAIL basic_sigma_transpose got=%0d exp=0", j_cfg_bad); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", err); end
        read_image(8, 8);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (got[r][c] !== expimg[r][c]) begin errors++;
                    $display("FAIL basic_img[%0d][%0d] got=%h exp=%h", r, c, got[r][c], expimg[r][c]); end
            end
    endtask

    task automatic test_rect_6x10();
        load_image(6, 10);
        run_job(6, 10, 3'd5, 1'b0);
        checks++; if (j_d1 !== {8'd6, 8'd10}) begin errors++; $display("FAIL rect_p1_dims got=%h exp=060a", j_d1); end
        checks++; if (j_d2 !== {8'd10, 8'd6}) begin errors++; $display("FAIL rect_p2_dims got=%h exp=0a06", j_d2); end
        checks++; if (j_done !== 1) begin errors++; $display("FAIL rect_done_pulses got=%0d exp=1", j_done); end
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 10; c++) begin
                checks++;
                if (buf_mem[c][r] !== exph[r][c]) begin errors++;
                    $display("FAIL rect_buf[%0d][%0d] got=%h exp=%h", c, r, buf_mem[c][r], exph[r][c]); end
            end
        read_image(6, 10);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 10; c++) begin
                checks++;
                if (got[r][c] !== expimg[r][c]) begin errors++;
                    $display("FAIL rect_img[%0d][%0d] got=%h exp=%h", r, c, got[r][c], expimg[r][c]); end
            end
    endtask

    task automatic test_illegal();
        int bad_r;
        run_job(8, 5, 3'd1, 1'b0);
        checks++; if (j_first_done !== 0) begin errors++; $display("FAIL illegal_done_latency got=%0d exp=0", j_first_done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b exp=1", err); end
        checks++; if (j_busy !== 1) begin errors++; $display("FAIL illegal_busy_cycles got=%0d exp=1", j_busy); end
        checks++; if (j_we !== 0) begin errors++; $display("FAIL illegal_write_en got=%0d exp=0", j_we); end
        checks++; if (j_rises !== 0) begin errors++; $display("FAIL illegal_rc_enable got=%0d exp=0", j_rises); end
        bad_r = int'($urandom_range(0, 5));
        run_job(bad_r, 12, 3'd0, 1'b0);
        checks++; if (err !== 1'b1 || j_done !== 1) begin errors++;
            $display("FAIL illegal_rows%0d got=err%b/done%0d exp=err1/done1", bad_r, err, j_done); end
    endtask

    task automatic test_back_to_back();
        load_image(8, 8);
        run_job(8, 8, 3'd3, 1'b1);
        checks++; if (j_err0 !== 1'b0) begin errors++; $display("FAIL b2b_err_clear got=%b exp=0", j_err0); end
        checks++; if (j_done !== 1) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=1", j_done); end
        checks++; if (j_rises !== 2) begin errors++; $display("FAIL b2b_pass_count got=%0d exp=2", j_rises); end
        checks++; if (j_host_dout !== 8'h00) begin errors++; $display("FAIL b2b_host_dout got=%h exp=00", j_host_dout); end
        checks++; if (j_poke_we !== 1'b0) begin errors++; $display("FAIL b2b_host_write_leak got=%b exp=0", j_poke_we); end
        checks++; if (j_d2 !== {8'd8, 8'd8}) begin errors++; $display("FAIL b2b_p2_dims got=%h exp=0808", j_d2); end
        read_image(8, 8);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (got[r][c] !== expimg[r][c]) begin errors++;
                    $display("FAIL b2b_img[%0d][%0d] got=%h exp=%h", r, c, got[r][c], expimg[r][c]); end
            end
    endtask

    task automatic test_reset_mid_run();
        bit hit, prev;
        int rises;
        load_image(8, 8);
        nrows = 8'd8; ncols = 8'd8; sigma = 3'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0; prev = 1'b0; rises = 0;
        for (int i = 0; i < 5000; i++) begin
            if (rc_rstn && !prev) rises++;
            prev = rc_rstn;
            if (rises == 2 && rc_busy) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrst_reach_p2 got=0 exp=1"); end
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (rc_rstn !== 1'b0) begin errors++; $display("FAIL midrst_rc_rstn got=%b exp=0", rc_rstn); end
        checks++; if (mem_img_if.req.write_en !== 1'b0 || mem_buf_if.req.write_en !== 1'b0) begin errors++;
            $display("FAIL midrst_write_en got=%b%b exp=00", mem_img_if.req.write_en, mem_buf_if.req.write_en); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL midrst_next_cycle got=busy%b/done%b exp=busy0/done0", busy, done); end
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load_image(8, 8);
        run_job(8, 8, 3'd6, 1'b0);
        checks++; if (!j_finished || j_done !== 1 || err !== 1'b0) begin errors++;
            $display("FAIL midrst_rerun got=fin%b/done%0d/err%b exp=fin1/done1/err0", j_finished, j_done, err); end
        read_image(8, 8);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (got[r][c] !== expimg[r][c]) begin errors++;
                    $display("FAIL midrst_img[%0d][%0d] got=%h exp=%h", r, c, got[r][c], expimg[r][c]); end
            end
    endtask

    task automatic test_random();
        int nr, nc;
        logic [2:0] sg;
        for (int k = 0; k < 2; k++) begin
            nr = int'($urandom_range(6, 12));
            nc = int'($urandom_range(6, 12));
            sg = 3'($urandom_range(0, 7));
            load_image(nr, nc);
            run_job(nr, nc, sg, 1'b0);
            checks++; if (j_d1 !== {8'(nr), 8'(nc)} || j_d2 !== {8'(nc), 8'(nr)}) begin errors++;
                $display("FAIL rand%0d_dims got=%h/%h exp=%02h%02h/%02h%02h", k, j_d1, j_d2, nr, nc, nc, nr); end
            checks++; if (j_done !== 1 || err !== 1'b0 || j_cfg_bad !== 0) begin errors++;
                $display("FAIL rand%0d_status got=done%0d/err%b/cfg%0d exp=done1/err0/cfg0", k, j_done, err, j_cfg_bad); end
            read_image(nr, nc);
            for (int r = 0; r < nr; r++)
                for (int c = 0; c < nc; c++) begin
                    checks++;
                    if (got[r][c] !== expimg[r][c]) begin errors++;
                        $display("FAIL rand%0d_img[%0d][%0d] got=%h exp=%h", k, r, c, got[r][c], expimg[r][c]); end
                end
        end
    endtask

`ifdef CONV_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        rc_hold = 1'b1;
        run_job(8, 8, 3'd2, 1'b0);
        rc_hold = 1'b0;
        checks++; if (j_done !== 1) begin errors++; $display("FAIL tmo_done_pulses got=%0d exp=1", j_done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b exp=1", err); end
        checks++; if (j_first_done - j_rise_cyc !== int'(TMO)) begin errors++;
            $display("FAIL tmo_latency got=%0d exp=%0d", j_first_done - j_rise_cyc, TMO); end
        repeat (4) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        host_if.req = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
`ifdef CONV_SCHED_TIMEOUT_EN
        test_illegal();
        test_timeout();
`else
        test_basic_8x8();
        test_rect_6x10();
        test_illegal();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
